// File: rtl/rtg4_ccc_lock_sequencer.sv
// Power-up/relock controller for the RTG4 fabric CCC: drives PLL_ARST_N, filters LOCK
// and releases per-domain resets in index order. Define CCC_LOCK_TIMEOUT_EN for WAIT_LOCK retry.
module rtg4_ccc_lock_sequencer #(
  parameter int NUM_DOMAINS     = 2,
  parameter int PLL_ARST_CYCLES = 64,
  parameter int LOCK_FILTER     = 1024,
  parameter int RST_STRETCH     = 16,
  parameter int RELOCK_TIMEOUT  = 65536
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   LOCK,
  input  logic                   SOFT_RESET,
  output logic                   PLL_ARST_N,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
  output logic                   READY,
  output logic                   LOCK_LOST,
  output logic [7:0]             RELOCK_COUNT,
  output logic [2:0]             DBG_STATE
);

  localparam int MAX_AF  = (PLL_ARST_CYCLES > LOCK_FILTER) ? PLL_ARST_CYCLES : LOCK_FILTER;
  localparam int CNT_MAX = (MAX_AF > RST_STRETCH) ? MAX_AF : RST_STRETCH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CW-1:0] ARST_LAST    = CW'(PLL_ARST_CYCLES - 1);
  localparam logic [CW-1:0] FILT_LAST    = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(RST_STRETCH - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [IW-1:0]            idx, idx_n;
  logic                     lock_m, lock_s;
  logic                     arst_n_n;
  logic [NUM_DOMAINS-1:0]   dom_n;
  logic                     ready_n;
  logic                     lost_n;
  logic [7:0]               count_n;
  logic                     enter_rel;
  logic                     lock_loss;

`ifdef CCC_LOCK_TIMEOUT_EN
  localparam int            TW       = $clog2(RELOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RELOCK_TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt, tmo_n;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_n;
    end
  end
`else
  // RELOCK_TIMEOUT has no effect in this build; this empty block only records its legal range.
  if (RELOCK_TIMEOUT < 1) begin : g_timeout_range
  end
`endif

  assign DBG_STATE = state;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    arst_n_n  = PLL_ARST_N;
    dom_n     = DOMAIN_RESET_N;
    ready_n   = READY;
    lost_n    = 1'b0;
    count_n   = RELOCK_COUNT;
    enter_rel = 1'b0;
    lock_loss = 1'b0;
`ifdef CCC_LOCK_TIMEOUT_EN
    tmo_n     = '0;
`endif
    if (SOFT_RESET) begin
      // Soft reset outranks a same-cycle lock loss, so no pulse and no count here.
      state_n  = S_PLL_RST;
      cnt_n    = '0;
      idx_n    = '0;
      arst_n_n = 1'b0;
      dom_n    = '0;
      ready_n  = 1'b0;
    end else begin
      unique case (state)
        S_PLL_RST: begin
          arst_n_n = 1'b0;
          if (cnt == ARST_LAST) begin
            state_n  = S_WAIT_LOCK;
            cnt_n    = '0;
            arst_n_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          arst_n_n = 1'b1;
          // The first synced-high cycle seen here already counts toward the filter.
          if (lock_s) begin
            if (LOCK_FILTER <= 1) begin
              enter_rel = 1'b1;
            end else begin
              state_n = S_FILTER;
              cnt_n   = CW'(1);
            end
          end
`ifdef CCC_LOCK_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state_n  = S_PLL_RST;
            cnt_n    = '0;
            arst_n_n = 1'b0;
          end else begin
            tmo_n = tmo_cnt + 1'b1;
          end
`endif
        end
        S_FILTER: begin
          if (!lock_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == FILT_LAST) begin
            enter_rel = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!lock_s) begin
            lock_loss = 1'b1;
          end else if (cnt == STRETCH_LAST) begin
            cnt_n      = '0;
            dom_n[idx] = 1'b1;
            if (idx == IDX_LAST) begin
              state_n = S_RUN;
              ready_n = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            lock_loss = 1'b1;
          end
        end
        default: begin
          state_n = S_PLL_RST;
          cnt_n   = '0;
        end
      endcase

      if (enter_rel) begin
        dom_n    = '0;
        dom_n[0] = 1'b1;
        cnt_n    = '0;
        if (NUM_DOMAINS == 1) begin
          state_n = S_RUN;
          ready_n = 1'b1;
          idx_n   = '0;
        end else begin
          state_n = S_RELEASE;
          idx_n   = IW'(1);
        end
      end

      if (lock_loss) begin
        state_n = S_WAIT_LOCK;
        cnt_n   = '0;
        idx_n   = '0;
        dom_n   = '0;
        ready_n = 1'b0;
        lost_n  = 1'b1;
        if (RELOCK_COUNT != 8'hFF) begin
          count_n = RELOCK_COUNT + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_PLL_RST;
      cnt            <= '0;
      idx            <= '0;
      lock_m         <= 1'b0;
      lock_s         <= 1'b0;
      PLL_ARST_N     <= 1'b0;
      DOMAIN_RESET_N <= '0;
      READY          <= 1'b0;
      LOCK_LOST      <= 1'b0;
      RELOCK_COUNT   <= '0;
    end else begin
      lock_m         <= LOCK;
      lock_s         <= lock_m;
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      PLL_ARST_N     <= arst_n_n;
      DOMAIN_RESET_N <= dom_n;
      READY          <= ready_n;
      LOCK_LOST      <= lost_n;
      RELOCK_COUNT   <= count_n;
    end
  end

endmodule

// File: tb/tb_rtg4_ccc_lock_sequencer.sv
// Bench for rtg4_ccc_lock_sequencer: phase-level reference model with an expected-output
// queue checked every cycle, plus directed timing checks of the documented scenarios.
module tb_rtg4_ccc_lock_sequencer;

  localparam int ND  = 2;
  localparam int PAC = 4;
  localparam int LF  = 8;
  localparam int RS  = 4;
  localparam int TO  = 32;
  localparam int W   = 1 + ND + 1 + 1 + 8;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_FILT = 2;
  localparam int P_REL  = 3;
  localparam int P_RUN  = 4;

  logic          clk = 1'b0;
  logic          RESET;
  logic          LOCK;
  logic          SOFT_RESET;
  logic          PLL_ARST_N;
  logic [ND-1:0] DOMAIN_RESET_N;
  logic          READY;
  logic          LOCK_LOST;
  logic [7:0]    RELOCK_COUNT;
  logic [2:0]    DBG_STATE;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  // clock / reset
  always #5 clk = ~clk;

  rtg4_ccc_lock_sequencer #(
    .NUM_DOMAINS    (ND),
    .PLL_ARST_CYCLES(PAC),
    .LOCK_FILTER    (LF),
    .RST_STRETCH    (RS),
    .RELOCK_TIMEOUT (TO)
  ) dut (
    .CLK           (clk),
    .RESET         (RESET),
    .LOCK          (LOCK),
    .SOFT_RESET    (SOFT_RESET),
    .PLL_ARST_N    (PLL_ARST_N),
    .DOMAIN_RESET_N(DOMAIN_RESET_N),
    .READY         (READY),
    .LOCK_LOST     (LOCK_LOST),
    .RELOCK_COUNT  (RELOCK_COUNT),
    .DBG_STATE     (DBG_STATE)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: phase + elapsed-time bookkeeping
  int m_phase    = P_RST;
  int m_rst_done = 0;
  int m_highs    = 0;
  int m_elapsed  = 0;
  int m_wait     = 0;
  int m_count    = 0;
  bit m_l1 = 1'b0, m_l2 = 1'b0, m_lost = 1'b0;

  function automatic logic [W-1:0] model_out();
    int         rel;
    logic [7:0] mask;
    rel = 0;
    if (m_phase == P_RUN) rel = ND;
    else if (m_phase == P_REL) rel = (1 + m_elapsed / RS < ND) ? 1 + m_elapsed / RS : ND;
    mask = 8'((1 << rel) - 1);
    return {m_phase != P_RST, mask[ND-1:0], m_phase == P_RUN, m_lost, m_count[7:0]};
  endfunction

  task automatic model_enter_release();
    m_elapsed = 0;
    m_phase   = (ND == 1) ? P_RUN : P_REL;
  endtask

  task automatic model_loss();
    m_lost  = 1'b1;
    m_count = (m_count < 255) ? m_count + 1 : 255;
    m_phase = P_WAIT;
    m_wait  = 0;
  endtask

  task automatic model_step();
    bit ls;
    ls = m_l2;
    if (RESET) begin
      m_phase = P_RST; m_rst_done = 0; m_highs = 0; m_elapsed = 0; m_wait = 0;
      m_count = 0; m_l1 = 1'b0; m_l2 = 1'b0; m_lost = 1'b0;
    end else begin
      m_l2   = m_l1;
      m_l1   = LOCK;
      m_lost = 1'b0;
      if (SOFT_RESET) begin
        m_phase    = P_RST;
        m_rst_done = 0;
      end else begin
        case (m_phase)
          P_RST: begin
            m_rst_done++;
            if (m_rst_done == PAC) begin
              m_phase = P_WAIT;
              m_wait  = 0;
            end
          end
          P_WAIT: begin
            if (ls) begin
              m_highs = 1;
              if (m_highs >= LF) model_enter_release();
              else m_phase = P_FILT;
            end else begin
              m_wait++;
`ifdef CCC_LOCK_TIMEOUT_EN
              if (m_wait == TO) begin
                m_phase    = P_RST;
                m_rst_done = 0;
              end
`endif
            end
          end
          P_FILT: begin
            if (ls) begin
              m_highs++;
              if (m_highs >= LF) model_enter_release();
            end else begin
              m_phase = P_WAIT;
              m_wait  = 0;
            end
          end
          P_REL: begin
            if (!ls) model_loss();
            else begin
              m_elapsed++;
              if (1 + m_elapsed / RS >= ND) m_phase = P_RUN;
            end
          end
          default: begin
            if (!ls) model_loss();
          end
        endcase
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    exp_q.push_back(model_out());
  end

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pll_arst_n",     PLL_ARST_N,     e[W-1]);
      chk("domain_reset_n", DOMAIN_RESET_N, e[W-2 -: ND]);
      chk("ready",          READY,          e[9]);
      chk("lock_lost",      LOCK_LOST,      e[8]);
      chk("relock_count",   RELOCK_COUNT,   e[7:0]);
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int budget, input string name, output int arst_lows);
    bit got;
    got       = 1'b0;
    arst_lows = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (!PLL_ARST_N) arst_lows++;
      if (READY) got = 1'b1;
    end
    chk(name, got, 1);
  endtask

  int            t_arst, t_b0, t_b1, t_drop, lows, lost_n, f1, f2;
  logic          rdy_b1, rdy_drop, prev_arst;
  logic [ND-1:0] dom_or;
  bit            found;

  initial begin
    RESET = 1'b1; LOCK = 1'b1; SOFT_RESET = 1'b0;
    cycles(3);
    chk("reset_arst_n", PLL_ARST_N, 0);
    chk("reset_domain", DOMAIN_RESET_N, 0);
    chk("reset_ready", READY, 0);
    chk("reset_lost", LOCK_LOST, 0);
    chk("reset_count", RELOCK_COUNT, 0);

    // power-up with LOCK held high
    RESET = 1'b0;
    t_arst = -1; t_b0 = -1; t_b1 = -1; rdy_b1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (t_arst < 0 && PLL_ARST_N) t_arst = i;
      if (t_b0 < 0 && DOMAIN_RESET_N[0]) t_b0 = i;
      if (t_b1 < 0 && DOMAIN_RESET_N[1]) begin t_b1 = i; rdy_b1 = READY; end
    end
    chk("arst_low_cycles", t_arst, PAC);
    chk("bit0_after_lock", t_b0 - t_arst, LF);
    chk("bit1_gap", t_b1 - t_b0, RS);
    chk("ready_with_bit1", rdy_b1, 1);

    // lock loss in RUN
    LOCK = 1'b0; t_drop = -1; rdy_drop = 1'b1; lost_n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (t_drop < 0 && DOMAIN_RESET_N == '0) begin t_drop = i; rdy_drop = READY; end
      lost_n += int'(LOCK_LOST);
    end
    chk("loss_latency", t_drop, 3);
    chk("loss_ready_low", rdy_drop, 0);
    chk("loss_pulse_width", lost_n, 1);
    chk("loss_count", RELOCK_COUNT, 1);
    LOCK = 1'b1;
    wait_ready(60, "relock_ready", lows);
    chk("relock_no_pll_reset", lows, 0);

    // SOFT_RESET in the same cycle the lock loss is seen
    LOCK = 1'b0; lost_n = 0;
    cycles(2);
    lost_n += int'(LOCK_LOST);
    SOFT_RESET = 1'b1;
    cycles(1);
    SOFT_RESET = 1'b0;
    lows = int'(!PLL_ARST_N);
    lost_n += int'(LOCK_LOST);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lows   += int'(!PLL_ARST_N);
      lost_n += int'(LOCK_LOST);
    end
    chk("soft_arst_low", lows, PAC);
    chk("soft_no_lost", lost_n, 0);
    chk("soft_count_kept", RELOCK_COUNT, 1);

    // glitchy lock never passes the filter
    RESET = 1'b1;
    cycles(2);
    RESET = 1'b0;
    dom_or = '0;
    for (int i = 0; i < 120; i++) begin
      LOCK = ((i % 6) != 5);
      @(negedge clk);
      dom_or |= DOMAIN_RESET_N;
    end
    chk("glitch_domains_held", dom_or, 0);
    chk("glitch_count", RELOCK_COUNT, 0);

    // WAIT_LOCK with no lock for a long time
    LOCK = 1'b1;
    wait_ready(60, "pre_timeout_ready", lows);
    LOCK = 1'b0; lows = 0; f1 = -1; f2 = -1; prev_arst = PLL_ARST_N;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (!PLL_ARST_N) lows++;
      if (prev_arst && !PLL_ARST_N) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      prev_arst = PLL_ARST_N;
    end
`ifdef CCC_LOCK_TIMEOUT_EN
    chk("timeout_period", f2 - f1, TO + PAC);
    chk("timeout_first", f1, 3 + TO);
`else
    chk("no_timeout_low", lows, 0);
`endif
    chk("timeout_count", RELOCK_COUNT, 1);

    // saturation of the relock counter
    for (int k = 0; k < 300; k++) begin
      LOCK = 1'b1;
      cycles($urandom_range(14, 22));
      LOCK = 1'b0;
      cycles($urandom_range(3, 6));
    end
    chk("count_saturated", RELOCK_COUNT, 255);

    // RESET in the middle of RELEASE
    LOCK = 1'b1; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (DOMAIN_RESET_N == 2'b01) found = 1'b1;
    end
    chk("reached_release", found, 1);
    RESET = 1'b1;
    cycles(1);
    chk("midrel_arst_n", PLL_ARST_N, 0);
    chk("midrel_domain", DOMAIN_RESET_N, 0);
    chk("midrel_ready", READY, 0);
    chk("midrel_lost", LOCK_LOST, 0);
    chk("midrel_count", RELOCK_COUNT, 0);
    RESET = 1'b0;

    // randomized traffic against the model
    for (int k = 0; k < 80; k++) begin
      LOCK = 1'(($urandom_range(0, 3)) != 0);
      if ($urandom_range(0, 9) == 0) begin
        SOFT_RESET = 1'b1;
        cycles($urandom_range(1, 3));
        SOFT_RESET = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        RESET = 1'b1;
        cycles(1);
        RESET = 1'b0;
      end
      cycles($urandom_range(1, 30));
    end

    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
